// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer for a 1-cycle-latency instruction memory.
// Owns the PC and tracks one in-flight response. Also handles halt, redirect and misaligned-redirect fault.
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        halt_req,
    input  logic        resume,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fault,
    output logic [31:0] fault_pc,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_pc_q, resp_pc_d;
    logic        fault_q, fault_d;
    logic [31:0] fault_pc_q, fault_pc_d;
    logic [31:0] count_q, count_d;

    logic        active;
    logic        misaligned;
    logic        fire;
    logic        drained;

    assign active     = (state_q == RUN) || (state_q == HALT);
    assign misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign imem_addr  = redirect_valid ? redirect_pc : pc_q;
    assign out_valid  = resp_valid_q && !redirect_valid && active;
    assign fire       = out_valid && out_ready;
    assign drained    = !resp_valid_q || fire;
    assign out_instr  = imem_rdata;
    assign out_pc     = resp_pc_q;
    assign fault      = fault_q;
    assign fault_pc   = fault_pc_q;
    assign fetch_count = count_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        resp_pc_d    = resp_pc_q;
        resp_valid_d = resp_valid_q && !fire;
        fault_d      = fault_q;
        fault_pc_d   = fault_pc_q;
        count_d      = fire ? count_q + 32'd1 : count_q;
        imem_en      = 1'b0;

        case (state_q)
            IDLE: begin
                imem_en = start;
                if (start) state_d = RUN;
            end
            RUN: begin
                if (misaligned) begin
                    state_d    = FAULT;
                    fault_d    = 1'b1;
                    fault_pc_d = redirect_pc;
                end else begin
                    imem_en = redirect_valid || (!halt_req && drained);
                    if (halt_req && drained && !redirect_valid) state_d = HALT;
                end
            end
            HALT: begin
                if (misaligned) begin
                    state_d    = FAULT;
                    fault_d    = 1'b1;
                    fault_pc_d = redirect_pc;
                end else begin
                    if (redirect_valid) pc_d = redirect_pc;
                    if (resume && !halt_req) state_d = RUN;
                end
            end
            default: ;
        endcase

        // A redirect in RUN/HALT always kills the pending response; an aligned
        // RUN redirect then replaces it through the issue path below.
        if (redirect_valid && active) resp_valid_d = 1'b0;

        if (imem_en) begin
            resp_valid_d = 1'b1;
            resp_pc_d    = imem_addr;
            pc_d         = imem_addr + PC_STEP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            resp_valid_q <= 1'b0;
            resp_pc_q    <= RESET_PC;
            fault_q      <= 1'b0;
            fault_pc_q   <= 32'd0;
            count_q      <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            resp_valid_q <= resp_valid_d;
            resp_pc_q    <= resp_pc_d;
            fault_q      <= fault_d;
            fault_pc_q   <= fault_pc_d;
            count_q      <= count_d;
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a registered-read memory model.
module tb_imem_fetch_ctrl;

    localparam logic [31:0] TAG = 32'hDEAD_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        halt_req = 1'b0;
    logic        resume = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fault;
    logic [31:0] fault_pc;
    logic [31:0] fetch_count;

    int n_cmp = 0;
    int n_err = 0;

    imem_fetch_ctrl #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
        .resume(resume), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .fault(fault), .fault_pc(fault_pc), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    // Memory: captures address on en, data word = address ^ TAG, held otherwise.
    always @(posedge clk) if (imem_en) imem_rdata <= imem_addr ^ TAG;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge, then let inputs be applied.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_en", 32'(imem_en), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_fault_pc", fault_pc, 32'd0);
        chk("rst_count", fetch_count, 32'd0);
        #10 rst_n = 1'b1;
        tick();

        // Start: first fetch at 0
        start = 1'b1; out_ready = 1'b1; settle();
        chk("start_en", 32'(imem_en), 32'd1);
        chk("start_addr", imem_addr, 32'h0);
        tick(); start = 1'b0; settle();
        chk("d0_valid", 32'(out_valid), 32'd1);
        chk("d0_pc", out_pc, 32'h0);
        chk("d0_instr", out_instr, 32'h0 ^ TAG);
        chk("d0_addr", imem_addr, 32'h4);
        tick(); settle();
        chk("d1_pc", out_pc, 32'h4);
        chk("d1_addr", imem_addr, 32'h8);
        chk("d1_count", fetch_count, 32'd1);
        tick();

        // Backpressure on 0x8
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_en", 32'(imem_en), 32'd0);
            chk("bp_pc", out_pc, 32'h8);
            chk("bp_instr", out_instr, 32'h8 ^ TAG);
            chk("bp_count", fetch_count, 32'd2);
            tick();
        end
        out_ready = 1'b1; settle();
        chk("bp_rel_en", 32'(imem_en), 32'd1);
        chk("bp_rel_addr", imem_addr, 32'hC);
        tick(); settle();
        chk("dC_pc", out_pc, 32'hC);
        tick();

        // Redirect while 0x10 in flight
        redirect_valid = 1'b1; redirect_pc = 32'h100; settle();
        chk("rd_valid", 32'(out_valid), 32'd0);
        chk("rd_en", 32'(imem_en), 32'd1);
        chk("rd_addr", imem_addr, 32'h100);
        chk("rd_count", fetch_count, 32'd4);
        tick(); redirect_valid = 1'b0; settle();
        chk("rd_pc100", out_pc, 32'h100);
        chk("rd_instr100", out_instr, 32'h100 ^ TAG);
        chk("rd_count2", fetch_count, 32'd4);
        tick(); settle();
        chk("rd_pc104", out_pc, 32'h104);
        chk("rd_count3", fetch_count, 32'd5);

        // Redirect to 0x20, then halt with 0x20 in flight
        redirect_valid = 1'b1; redirect_pc = 32'h20; settle();
        tick(); redirect_valid = 1'b0; halt_req = 1'b1; settle();
        chk("h_valid", 32'(out_valid), 32'd1);
        chk("h_pc", out_pc, 32'h20);
        chk("h_en", 32'(imem_en), 32'd0);
        tick(); settle();
        chk("h_count", fetch_count, 32'd6);
        chk("h_valid2", 32'(out_valid), 32'd0);
        chk("h_en2", 32'(imem_en), 32'd0);
        tick(); settle();
        chk("h_en3", 32'(imem_en), 32'd0);
        halt_req = 1'b0; resume = 1'b1; settle();
        chk("h_res_en", 32'(imem_en), 32'd0);
        tick(); resume = 1'b0; settle();
        chk("res_en", 32'(imem_en), 32'd1);
        chk("res_addr", imem_addr, 32'h24);
        tick(); settle();
        chk("res_pc", out_pc, 32'h24);

        // Halt again, redirect while halted, resume
        halt_req = 1'b1; settle();
        tick(); halt_req = 1'b0; settle();
        chk("h2_count", fetch_count, 32'd7);
        redirect_valid = 1'b1; redirect_pc = 32'h200; settle();
        chk("hr_en", 32'(imem_en), 32'd0);
        chk("hr_valid", 32'(out_valid), 32'd0);
        tick(); redirect_valid = 1'b0; resume = 1'b1; settle();
        chk("hr_en2", 32'(imem_en), 32'd0);
        tick(); resume = 1'b0; settle();
        chk("hr_res_en", 32'(imem_en), 32'd1);
        chk("hr_res_addr", imem_addr, 32'h200);
        tick(); settle();
        chk("hr_pc", out_pc, 32'h200);
        chk("hr_instr", out_instr, 32'h200 ^ TAG);

        // Wrap at top of address space
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; settle();
        chk("w_addr", imem_addr, 32'hFFFF_FFFC);
        tick(); redirect_valid = 1'b0; settle();
        chk("w_pc", out_pc, 32'hFFFF_FFFC);
        chk("w_next", imem_addr, 32'h0);
        tick(); settle();
        chk("w_pc0", out_pc, 32'h0);
        chk("w_count", fetch_count, 32'd8);

        // Asynchronous reset mid-stream
        rst_n = 1'b0; settle();
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_en", 32'(imem_en), 32'd0);
        chk("ar_count", fetch_count, 32'd0);
        rst_n = 1'b1;
        tick(); tick(); settle();
        chk("ar_idle_valid", 32'(out_valid), 32'd0);
        chk("ar_idle_en", 32'(imem_en), 32'd0);
        start = 1'b1; settle();
        chk("ar_start_addr", imem_addr, 32'h0);
        tick(); start = 1'b0; settle();
        chk("ar_d0_pc", out_pc, 32'h0);
        chk("ar_d0_valid", 32'(out_valid), 32'd1);

        // Misaligned redirect -> FAULT
        redirect_valid = 1'b1; redirect_pc = 32'h102; settle();
        chk("f_en", 32'(imem_en), 32'd0);
        chk("f_valid", 32'(out_valid), 32'd0);
        tick(); redirect_valid = 1'b0; start = 1'b1; resume = 1'b1; settle();
        chk("f_fault", 32'(fault), 32'd1);
        chk("f_fault_pc", fault_pc, 32'h102);
        chk("f_en2", 32'(imem_en), 32'd0);
        chk("f_valid2", 32'(out_valid), 32'd0);
        tick(); settle();
        chk("f_en3", 32'(imem_en), 32'd0);
        chk("f_valid3", 32'(out_valid), 32'd0);
        chk("f_fault2", 32'(fault), 32'd1);
        start = 1'b0; resume = 1'b0;
        rst_n = 1'b0; settle();
        chk("f_clr", 32'(fault), 32'd0);
        chk("f_clr_pc", fault_pc, 32'd0);
        rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
Instruction-fetch sequencer in front of the RV32I instruction memory, which has a 1-cycle latency because its address is registered on en. The block owns the PC, issues word-aligned fetches and tracks the one in-flight response. It delivers instructions to decode over a valid/ready handshake, and handles start, halt/resume, branch redirect with in-flight kill, and misaligned-redirect fault.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded at reset; first address fetched after start.
PC_STEP, 4, byte increment between sequential fetches.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  pulse; leaves IDLE and begins fetching at RESET_PC.
halt_req  in  1  level; stop issuing new fetches.
resume  in  1  pulse; HALT -> RUN.
redirect_valid  in  1  branch/jump redirect this cycle.
redirect_pc  in  32  redirect target, byte address.
imem_en  out  1  memory address-capture enable (combinational).
imem_addr  out  32  memory byte address (combinational).
imem_rdata  in  32  memory data for the previously captured address; held while imem_en=0.
out_valid  out  1  instruction available to decode.
out_ready  in  1  decode accepts.
out_instr  out  32  instruction (passes through imem_rdata).
out_pc  out  32  PC of out_instr.
fault  out  1  sticky; misaligned redirect seen.
fault_pc  out  32  offending redirect_pc.
fetch_count  out  32  number of handshakes completed (out_valid & out_ready).

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, pc_q=RESET_PC, resp_valid_q=0, resp_pc_q=RESET_PC.
  - fault=0, fault_pc=0, fetch_count=0.
  - Outputs: imem_en=0, out_valid=0.
  - Reset asserted mid-operation drops the in-flight response and does not deliver it.
- imem_addr = redirect_valid ? redirect_pc : pc_q in every state.
- fire = out_valid & out_ready.
- Issue: when imem_en=1 at a posedge:
  - resp_valid_q<=1, resp_pc_q<=imem_addr, pc_q<=imem_addr+PC_STEP, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
  - Otherwise resp_valid_q<=resp_valid_q & ~fire.
- out_valid = resp_valid_q & ~redirect_valid & (state is RUN or HALT).
- out_instr=imem_rdata, out_pc=resp_pc_q.
- Data stays stable while stalled, because imem_en=0 freezes the memory output.
- Latency: 1 cycle from issue to out_valid. Sustained throughput is 1 instruction/cycle with out_ready=1.
- FSM states: IDLE, RUN, HALT, FAULT.
  - IDLE:
    - imem_en=start.
    - start -> RUN; that cycle fetches RESET_PC.
    - redirect ignored.
  - RUN:
    - imem_en = redirect_valid | (~halt_req & (~resp_valid_q | fire)).
    - halt_req -> HALT once the response has drained: (~resp_valid_q | fire) and no redirect that cycle.
  - HALT:
    - A pending response is still deliverable.
    - imem_en=0; redirect_valid only updates pc_q<=redirect_pc and kills any pending response.
    - resume & ~halt_req -> RUN; the next fetch is at pc_q.
  - Redirect priority: redirect > halt > sequential.
    - Redirect kills the in-flight response: no delivery, no count.
    - In RUN it issues redirect_pc in the same cycle, even if out_ready=0.
  - Misaligned redirect (redirect_valid & redirect_pc[1:0]!=0 in RUN or HALT):
    - Go to FAULT; fault<=1, fault_pc<=redirect_pc.
    - No issue that cycle, in-flight response killed.
  - FAULT: imem_en=0, out_valid=0, all inputs ignored; exit only via rst_n.
- fetch_count increments on fire and wraps modulo 2^32.
- Simultaneous start+halt_req in IDLE: go RUN with the fetch issued, then halt as above.
- resume outside HALT: ignored.

Test Plan:
- Reset, start, out_ready=1 -> imem_addr 0x0,0x4,0x8… on consecutive cycles. First out_valid one cycle after start with out_pc=0x0; after 5 cycles of delivery fetch_count=5.
- Backpressure: out_ready=0 for 3 cycles while out_pc=0x8 -> imem_en=0, out_instr/out_pc stable for 3 cycles; no PC advance; 0xC issued the cycle ready returns.
- Redirect to 0x100 while 0x10 is in flight -> 0x10 never delivered; imem_addr=0x100 with imem_en=1 that cycle; next out_pc=0x100, then 0x104; count excludes 0x10.
- halt_req with 0x20 in flight -> 0x20 delivered, then imem_en=0 and state HALT. resume -> next fetch 0x24. Redirect 0x200 while halted then resume -> fetch 0x200.
- Redirect to 0x102 -> fault=1, fault_pc=0x102, out_valid=0, imem_en=0 thereafter; start/resume ignored; rst_n low clears fault.
- Wrap: redirect to 0xFFFFFFFC, ready=1 -> next fetch 0x00000000. Async rst_n pulse mid-stream -> out_valid=0 immediately, no delivery until a new start.
